// File: rtl/mc_ctrl_fsm_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: ALUOp, opcode/funct,
// datapath select values, FSM states and decoder instruction classes.
package mc_ctrl_fsm_pkg;

    localparam logic [1:0] ALUOP_ADDU = 2'b00;
    localparam logic [1:0] ALUOP_SUBU = 2'b01;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUBU = 6'b100011;

    localparam logic [1:0] ALUSRCB_B      = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR   = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM    = 2'b10;
    localparam logic [1:0] ALUSRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic MEMTOREG_ALU = 1'b0;
    localparam logic MEMTOREG_MDR = 1'b1;

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_EXEC     = 4'd2,
        ST_RTYPE_WB = 4'd3,
        ST_MEMADR   = 4'd4,
        ST_MEMRD    = 4'd5,
        ST_MEMWB    = 4'd6,
        ST_MEMWR    = 4'd7,
        ST_ADDI_EX  = 4'd8,
        ST_ADDI_WB  = 4'd9,
        ST_BRANCH   = 4'd10,
        ST_JUMP     = 4'd11,
        ST_HALT     = 4'd12
    } state_t;

    typedef enum logic [2:0] {
        CLS_RTYPE   = 3'd0,
        CLS_MEM     = 3'd1,
        CLS_ADDI    = 3'd2,
        CLS_BRANCH  = 3'd3,
        CLS_JUMP    = 3'd4,
        CLS_ILLEGAL = 3'd5
    } dec_class_t;

endpackage

// File: rtl/mc_ctrl_fsm_decode.sv
// Combinational instruction decoder: opcode/funct to instruction class,
// load/store select and the ALUOp used in the R-type EXEC state.
module mc_ctrl_fsm_decode
    import mc_ctrl_fsm_pkg::*;
(
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_funct,
    output dec_class_t o_class,
    output logic       o_is_store,
    output logic [1:0] o_exec_alu_op
);

    always_comb begin
        o_class    = CLS_ILLEGAL;
        o_is_store = 1'b0;
        case (i_opcode)
            OP_RTYPE: o_class = CLS_RTYPE;
            OP_LW:    o_class = CLS_MEM;
            OP_SW: begin
                o_class    = CLS_MEM;
                o_is_store = 1'b1;
            end
            OP_ADDIU: o_class = CLS_ADDI;
            OP_BEQ:   o_class = CLS_BRANCH;
            OP_J:     o_class = CLS_JUMP;
            default:  o_class = CLS_ILLEGAL;
        endcase
    end

    // Only subu selects subtraction; addu and any other funct add.
    assign o_exec_alu_op = (i_funct == FN_SUBU) ? ALUOP_SUBU : ALUOP_ADDU;

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control FSM. Define MC_CTRL_ILLEGAL_TRAP_EN to trap
// unsupported opcodes into HALT (with illegal_op); otherwise they act as NOPs.
module mc_ctrl_fsm
    import mc_ctrl_fsm_pkg::*;
#(
    parameter int FETCH_WAIT_MAX = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       instr_done,
    output logic       timeout,
    output state_t     dbg_state
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    ,
    output logic       illegal_op
`endif
);

    localparam int CW = (FETCH_WAIT_MAX < 2) ? 1 : $clog2(FETCH_WAIT_MAX + 1);
    localparam logic [CW-1:0] CNT_MAX = '1;

    state_t     r_state;
    logic [CW-1:0] r_wait_cnt;
    logic       r_timeout;
    dec_class_t w_class;
    logic       w_is_store;
    logic [1:0] w_exec_alu_op;
    logic       w_waiting;

    mc_ctrl_fsm_decode u_decode (
        .i_opcode      (opcode),
        .i_funct       (funct),
        .o_class       (w_class),
        .o_is_store    (w_is_store),
        .o_exec_alu_op (w_exec_alu_op)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_FETCH;
        end else begin
            case (r_state)
                ST_FETCH:    if (mem_ready) r_state <= ST_DECODE;
                ST_DECODE: begin
                    case (w_class)
                        CLS_RTYPE:  r_state <= ST_EXEC;
                        CLS_MEM:    r_state <= ST_MEMADR;
                        CLS_ADDI:   r_state <= ST_ADDI_EX;
                        CLS_BRANCH: r_state <= ST_BRANCH;
                        CLS_JUMP:   r_state <= ST_JUMP;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                        default:    r_state <= ST_HALT;
`else
                        default:    r_state <= ST_FETCH;
`endif
                    endcase
                end
                ST_EXEC:     r_state <= ST_RTYPE_WB;
                ST_MEMADR:   r_state <= w_is_store ? ST_MEMWR : ST_MEMRD;
                ST_MEMRD:    if (mem_ready) r_state <= ST_MEMWB;
                ST_MEMWR:    if (mem_ready) r_state <= ST_FETCH;
                ST_ADDI_EX:  r_state <= ST_ADDI_WB;
                ST_HALT:     r_state <= ST_HALT;
                default:     r_state <= ST_FETCH;
            endcase
        end
    end

    // Waiting states only exit on mem_ready, so clearing whenever we are not
    // stalled also covers the clear-on-state-change case.
    assign w_waiting = (r_state inside {ST_FETCH, ST_MEMRD, ST_MEMWR}) && !mem_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait_cnt <= '0;
            r_timeout  <= 1'b0;
        end else if (w_waiting) begin
            if (r_wait_cnt != CNT_MAX) r_wait_cnt <= r_wait_cnt + 1'b1;
            if ((FETCH_WAIT_MAX != 0) && (32'(r_wait_cnt) + 32'd1 >= 32'(FETCH_WAIT_MAX)))
                r_timeout <= 1'b1;
        end else begin
            r_wait_cnt <= '0;
        end
    end

    always_comb begin
        pc_write   = 1'b0;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = MEMTOREG_ALU;
        alu_src_a  = 1'b0;
        alu_src_b  = ALUSRCB_B;
        alu_op     = ALUOP_ADDU;
        pc_source  = PCSRC_ALU;
        instr_done = 1'b0;
        case (r_state)
            ST_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = ALUSRCB_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            ST_DECODE: begin
                alu_src_b  = ALUSRCB_IMM_SH;
`ifndef MC_CTRL_ILLEGAL_TRAP_EN
                instr_done = (w_class == CLS_ILLEGAL);
`endif
            end
            ST_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = w_exec_alu_op;
            end
            ST_RTYPE_WB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
            end
            ST_MEMADR, ST_ADDI_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = ALUSRCB_IMM;
            end
            ST_MEMRD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            ST_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = MEMTOREG_MDR;
                instr_done = 1'b1;
            end
            ST_MEMWR: begin
                mem_write  = 1'b1;
                i_or_d     = 1'b1;
                instr_done = mem_ready;
            end
            ST_ADDI_WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            ST_BRANCH: begin
                alu_src_a  = 1'b1;
                alu_op     = ALUOP_SUBU;
                pc_source  = PCSRC_ALUOUT;
                pc_write   = zero;
                instr_done = 1'b1;
            end
            ST_JUMP: begin
                pc_source  = PCSRC_JUMP;
                pc_write   = 1'b1;
                instr_done = 1'b1;
            end
            default: ;
        endcase
        // Nothing may be written or requested while reset is held.
        if (rst) begin
            pc_write   = 1'b0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            ir_write   = 1'b0;
            reg_write  = 1'b0;
            instr_done = 1'b0;
        end
    end

    assign timeout   = r_timeout;
    assign dbg_state = r_state;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    assign illegal_op = (r_state == ST_HALT);
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm (FETCH_WAIT_MAX = 4); covers both builds of
// MC_CTRL_ILLEGAL_TRAP_EN.
module tb_mc_ctrl_fsm;
    import mc_ctrl_fsm_pkg::*;

    logic clk, rst, zero, mem_ready;
    logic [5:0] opcode, funct;
    logic pc_write, i_or_d, mem_read, mem_write, ir_write, reg_write, reg_dst;
    logic mem_to_reg, alu_src_a, instr_done, timeout;
    logic [1:0] alu_src_b, alu_op, pc_source;
    state_t dbg_state;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    logic illegal_op;
`endif

    int total = 0;
    int bad   = 0;

    mc_ctrl_fsm #(.FETCH_WAIT_MAX(4)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pc_write(pc_write), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .instr_done(instr_done), .timeout(timeout),
        .dbg_state(dbg_state)
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        , .illegal_op(illegal_op)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Control word order: pc_write, i_or_d, mem_read, mem_write, ir_write,
    // reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source, instr_done
    function automatic logic [15:0] ctl();
        return {pc_write, i_or_d, mem_read, mem_write, ir_write, reg_write, reg_dst,
                mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source, instr_done};
    endfunction

    localparam logic [15:0] E_FETCH    = {1'b1,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0};
    localparam logic [15:0] E_FETCH_W  = {1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0};
    localparam logic [15:0] E_DEC      = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,2'b00,1'b0};
    localparam logic [15:0] E_DEC_NOP  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,2'b00,1'b1};
    localparam logic [15:0] E_EXEC_ADD = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,2'b00,1'b0};
    localparam logic [15:0] E_EXEC_SUB = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,2'b00,1'b0};
    localparam logic [15:0] E_RWB      = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,2'b00,2'b00,2'b00,1'b1};
    localparam logic [15:0] E_MEMADR   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b00,1'b0};
    localparam logic [15:0] E_MEMRD    = {1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0};
    localparam logic [15:0] E_MEMWB    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,1'b1};
    localparam logic [15:0] E_MEMWR_W  = {1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0};
    localparam logic [15:0] E_MEMWR_R  = {1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b1};
    localparam logic [15:0] E_ADDI_WB  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b1};
    localparam logic [15:0] E_BR_T     = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,2'b01,1'b1};
    localparam logic [15:0] E_BR_NT    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,2'b01,1'b1};
    localparam logic [15:0] E_JUMP     = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b10,1'b1};
    // Write/request/done bits that must be low while rst is high.
    localparam logic [15:0] M_WR       = {1'b1,1'b0,1'b1,1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b1};

    task automatic test_reset();
        rst = 1'b1; mem_ready = 1'b1; zero = 1'b0; opcode = OP_RTYPE; funct = FN_ADDU;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            total++;
            if ((ctl() & M_WR) !== 16'h0) begin
                bad++; $display("FAIL reset_hold cyc%0d got=%h exp=%h", i, ctl() & M_WR, 16'h0);
            end
        end
        rst = 1'b0; #1;
        total++;
        if ({dbg_state, ctl(), timeout} !== {ST_FETCH, E_FETCH, 1'b0}) begin
            bad++; $display("FAIL reset_first_fetch got=%h/%h/%b exp=%h/%h/0", dbg_state, ctl(), timeout, ST_FETCH, E_FETCH);
        end
    endtask

    task automatic test_addu();
        logic [15:0] ex [4] = '{E_FETCH, E_DEC, E_EXEC_ADD, E_RWB};
        state_t      st [4] = '{ST_FETCH, ST_DECODE, ST_EXEC, ST_RTYPE_WB};
        opcode = OP_RTYPE; funct = FN_ADDU; mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1; total++;
            if ({dbg_state, ctl()} !== {st[i], ex[i]}) begin
                bad++; $display("FAIL addu cyc%0d got=%h/%h exp=%h/%h", i, dbg_state, ctl(), st[i], ex[i]);
            end
            @(posedge clk); #1;
        end
        total++;
        if (dbg_state !== ST_FETCH) begin bad++; $display("FAIL addu_len got=%h exp=%h", dbg_state, ST_FETCH); end
    endtask

    task automatic test_subu();
        logic [15:0] ex [4] = '{E_FETCH, E_DEC, E_EXEC_SUB, E_RWB};
        state_t      st [4] = '{ST_FETCH, ST_DECODE, ST_EXEC, ST_RTYPE_WB};
        opcode = OP_RTYPE; funct = FN_SUBU; mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1; total++;
            if ({dbg_state, ctl()} !== {st[i], ex[i]}) begin
                bad++; $display("FAIL subu cyc%0d got=%h/%h exp=%h/%h", i, dbg_state, ctl(), st[i], ex[i]);
            end
            @(posedge clk); #1;
        end
        total++;
        if (dbg_state !== ST_FETCH) begin bad++; $display("FAIL subu_len got=%h exp=%h", dbg_state, ST_FETCH); end
    endtask

    task automatic test_addiu();
        logic [15:0] ex [4] = '{E_FETCH, E_DEC, E_MEMADR, E_ADDI_WB};
        state_t      st [4] = '{ST_FETCH, ST_DECODE, ST_ADDI_EX, ST_ADDI_WB};
        opcode = OP_ADDIU; funct = 6'b000000; mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1; total++;
            if ({dbg_state, ctl()} !== {st[i], ex[i]}) begin
                bad++; $display("FAIL addiu cyc%0d got=%h/%h exp=%h/%h", i, dbg_state, ctl(), st[i], ex[i]);
            end
            @(posedge clk); #1;
        end
        total++;
        if (dbg_state !== ST_FETCH) begin bad++; $display("FAIL addiu_len got=%h exp=%h", dbg_state, ST_FETCH); end
    endtask

    task automatic test_lw_wait();
        logic [15:0] ex [8] = '{E_FETCH, E_DEC, E_MEMADR, E_MEMRD, E_MEMRD, E_MEMRD, E_MEMRD, E_MEMWB};
        state_t      st [8] = '{ST_FETCH, ST_DECODE, ST_MEMADR, ST_MEMRD, ST_MEMRD, ST_MEMRD, ST_MEMRD, ST_MEMWB};
        logic        mr [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        opcode = OP_LW;
        for (int i = 0; i < 8; i++) begin
            mem_ready = mr[i];
            #1; total++;
            if ({dbg_state, ctl()} !== {st[i], ex[i]}) begin
                bad++; $display("FAIL lw cyc%0d got=%h/%h exp=%h/%h", i, dbg_state, ctl(), st[i], ex[i]);
            end
            @(posedge clk); #1;
        end
        mem_ready = 1'b1;
        total++;
        if ({dbg_state, timeout} !== {ST_FETCH, 1'b0}) begin
            bad++; $display("FAIL lw_len got=%h/%b exp=%h/0", dbg_state, timeout, ST_FETCH);
        end
    endtask

    task automatic test_sw();
        logic [15:0] ex [4] = '{E_FETCH, E_DEC, E_MEMADR, E_MEMWR_R};
        state_t      st [4] = '{ST_FETCH, ST_DECODE, ST_MEMADR, ST_MEMWR};
        opcode = OP_SW; mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1; total++;
            if ({dbg_state, ctl()} !== {st[i], ex[i]}) begin
                bad++; $display("FAIL sw cyc%0d got=%h/%h exp=%h/%h", i, dbg_state, ctl(), st[i], ex[i]);
            end
            @(posedge clk); #1;
        end
        total++;
        if (dbg_state !== ST_FETCH) begin bad++; $display("FAIL sw_len got=%h exp=%h", dbg_state, ST_FETCH); end
    endtask

    task automatic test_beq();
        logic [15:0] ex [3];
        state_t      st [3] = '{ST_FETCH, ST_DECODE, ST_BRANCH};
        opcode = OP_BEQ; mem_ready = 1'b1;
        for (int z = 1; z >= 0; z--) begin
            zero = (z == 1);
            ex = '{E_FETCH, E_DEC, (z == 1) ? E_BR_T : E_BR_NT};
            for (int i = 0; i < 3; i++) begin
                #1; total++;
                if ({dbg_state, ctl()} !== {st[i], ex[i]}) begin
                    bad++; $display("FAIL beq_z%0d cyc%0d got=%h/%h exp=%h/%h", z, i, dbg_state, ctl(), st[i], ex[i]);
                end
                @(posedge clk); #1;
            end
            total++;
            if (dbg_state !== ST_FETCH) begin bad++; $display("FAIL beq_len_z%0d got=%h exp=%h", z, dbg_state, ST_FETCH); end
        end
        zero = 1'b0;
    endtask

    task automatic test_jump();
        logic [15:0] ex [3] = '{E_FETCH, E_DEC, E_JUMP};
        state_t      st [3] = '{ST_FETCH, ST_DECODE, ST_JUMP};
        opcode = OP_J; mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1; total++;
            if ({dbg_state, ctl()} !== {st[i], ex[i]}) begin
                bad++; $display("FAIL jump cyc%0d got=%h/%h exp=%h/%h", i, dbg_state, ctl(), st[i], ex[i]);
            end
            @(posedge clk); #1;
        end
        total++;
        if (dbg_state !== ST_FETCH) begin bad++; $display("FAIL jump_len got=%h exp=%h", dbg_state, ST_FETCH); end
    endtask

    // 2 fetch stalls plus 3 store stalls: a counter that fails to clear
    // between them would reach 4 and raise timeout.
    task automatic test_wait_clear();
        logic [15:0] ex [9] = '{E_FETCH_W, E_FETCH_W, E_FETCH, E_DEC, E_MEMADR,
                                E_MEMWR_W, E_MEMWR_W, E_MEMWR_W, E_MEMWR_R};
        state_t      st [9] = '{ST_FETCH, ST_FETCH, ST_FETCH, ST_DECODE, ST_MEMADR,
                                ST_MEMWR, ST_MEMWR, ST_MEMWR, ST_MEMWR};
        logic        mr [9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        opcode = OP_SW;
        for (int i = 0; i < 9; i++) begin
            mem_ready = mr[i];
            #1; total++;
            if ({dbg_state, ctl(), timeout} !== {st[i], ex[i], 1'b0}) begin
                bad++; $display("FAIL wait_clear cyc%0d got=%h/%h/%b exp=%h/%h/0", i, dbg_state, ctl(), timeout, st[i], ex[i]);
            end
            @(posedge clk); #1;
        end
        mem_ready = 1'b1;
        total++;
        if ({dbg_state, timeout} !== {ST_FETCH, 1'b0}) begin
            bad++; $display("FAIL wait_clear_end got=%h/%b exp=%h/0", dbg_state, timeout, ST_FETCH);
        end
    endtask

    task automatic test_illegal();
        opcode = 6'b111111; mem_ready = 1'b1;
        #1; total++;
        if ({dbg_state, ctl()} !== {ST_FETCH, E_FETCH}) begin
            bad++; $display("FAIL illegal_fetch got=%h/%h exp=%h/%h", dbg_state, ctl(), ST_FETCH, E_FETCH);
        end
        @(posedge clk); #1;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        total++;
        if ({dbg_state, ctl()} !== {ST_DECODE, E_DEC}) begin
            bad++; $display("FAIL illegal_decode got=%h/%h exp=%h/%h", dbg_state, ctl(), ST_DECODE, E_DEC);
        end
        opcode = OP_RTYPE;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            total++;
            if ({dbg_state, ctl(), illegal_op} !== {ST_HALT, 16'h0, 1'b1}) begin
                bad++; $display("FAIL illegal_halt cyc%0d got=%h/%h/%b exp=%h/0000/1", i, dbg_state, ctl(), illegal_op, ST_HALT);
            end
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; #1;
        total++;
        if ({dbg_state, ctl(), illegal_op} !== {ST_FETCH, E_FETCH, 1'b0}) begin
            bad++; $display("FAIL illegal_rst got=%h/%h/%b exp=%h/%h/0", dbg_state, ctl(), illegal_op, ST_FETCH, E_FETCH);
        end
`else
        total++;
        if ({dbg_state, ctl()} !== {ST_DECODE, E_DEC_NOP}) begin
            bad++; $display("FAIL illegal_nop got=%h/%h exp=%h/%h", dbg_state, ctl(), ST_DECODE, E_DEC_NOP);
        end
        @(posedge clk); #1;
        total++;
        if (dbg_state !== ST_FETCH) begin bad++; $display("FAIL illegal_len got=%h exp=%h", dbg_state, ST_FETCH); end
`endif
    endtask

    task automatic test_sw_reset();
        logic [15:0] ex [4] = '{E_FETCH, E_DEC, E_MEMADR, E_MEMWR_W};
        state_t      st [4] = '{ST_FETCH, ST_DECODE, ST_MEMADR, ST_MEMWR};
        logic        mr [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        opcode = OP_SW;
        for (int i = 0; i < 4; i++) begin
            mem_ready = mr[i];
            #1; total++;
            if ({dbg_state, ctl()} !== {st[i], ex[i]}) begin
                bad++; $display("FAIL sw_rst cyc%0d got=%h/%h exp=%h/%h", i, dbg_state, ctl(), st[i], ex[i]);
            end
            @(posedge clk); #1;
        end
        mem_ready = 1'b0; rst = 1'b1; #1;
        total++;
        if ((ctl() & M_WR) !== 16'h0) begin
            bad++; $display("FAIL sw_rst_hold got=%h exp=%h", ctl() & M_WR, 16'h0);
        end
        @(posedge clk); #1;
        rst = 1'b0; mem_ready = 1'b1; #1;
        total++;
        if ({dbg_state, ctl()} !== {ST_FETCH, E_FETCH}) begin
            bad++; $display("FAIL sw_rst_after got=%h/%h exp=%h/%h", dbg_state, ctl(), ST_FETCH, E_FETCH);
        end
    endtask

    task automatic test_timeout();
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1; total++;
            if ({dbg_state, timeout} !== {ST_FETCH, 1'b0}) begin
                bad++; $display("FAIL timeout_early cyc%0d got=%h/%b exp=%h/0", i, dbg_state, timeout, ST_FETCH);
            end
            @(posedge clk); #1;
        end
        total++;
        if ({dbg_state, timeout} !== {ST_FETCH, 1'b1}) begin
            bad++; $display("FAIL timeout_rise got=%h/%b exp=%h/1", dbg_state, timeout, ST_FETCH);
        end
        // Run well past the counter's saturation point; timeout stays set.
        repeat (8) begin @(posedge clk); #1; end
        total++;
        if ({dbg_state, timeout} !== {ST_FETCH, 1'b1}) begin
            bad++; $display("FAIL timeout_sticky got=%h/%b exp=%h/1", dbg_state, timeout, ST_FETCH);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; mem_ready = 1'b1; #1;
        total++;
        if ({dbg_state, timeout} !== {ST_FETCH, 1'b0}) begin
            bad++; $display("FAIL timeout_clear got=%h/%b exp=%h/0", dbg_state, timeout, ST_FETCH);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; mem_ready = 1'b1; zero = 1'b0; opcode = '0; funct = '0;
        test_reset();
        test_addu();
        test_subu();
        test_addiu();
        test_lw_wait();
        test_sw();
        test_beq();
        test_jump();
        test_wait_clear();
        test_illegal();
        test_sw_reset();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
